// File: rtl/siggen_pkg.sv
// Shared types for the sample-path blocks: delay writer FSM states and default sample/address widths.
package siggen_pkg;

  typedef enum logic {CLEAR, RUN} delay_state_t;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]    sample_t;

endpackage

// File: rtl/ram_delay_writer.sv
// Write/read initiator for the dual-port delay RAM. It zeroes the RAM after reset, then writes one sample
// per accept and reads the location OFFSET samples back, returning it two cycles after the accept.
//
// Handshake: a sample is taken on every posedge where in_valid && in_ready; in_ready is registered and
// stays high for the whole RUN phase. out_valid is a one-cycle pulse per accept with no backpressure.
module ram_delay_writer
  import siggen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_primed,
  output logic [ADDRESS_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic [ADDRESS_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  delay_state_t             state;
  logic [ADDRESS_WIDTH:0]   clr_ptr;
  logic [ADDRESS_WIDTH:0]   fill;
  logic [ADDRESS_WIDTH-1:0] wp;
  logic [ADDRESS_WIDTH-1:0] offset_q;
  logic                     acc_d;
  logic                     primed_d;

  logic                     accept;
  logic                     offset_changed;
  logic [ADDRESS_WIDTH:0]   eff_offset;

  // Offset 0 reads the slot about to be overwritten, so it behaves as a full-depth delay.
  always_comb begin
    accept         = in_valid & in_ready;
    offset_changed = (offset != offset_q);
    eff_offset     = (offset == '0) ? DEPTH : {1'b0, offset};
  end

  assign out_data = ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      wp         <= '0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      ram_raddr  <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_primed <= 1'b0;
      fill       <= '0;
      offset_q   <= '0;
      acc_d      <= 1'b0;
      primed_d   <= 1'b0;
    end else begin
      // Two-stage return: addresses settle one cycle, the RAM registers its read the next.
      out_valid  <= acc_d;
      out_primed <= primed_d;
      acc_d      <= 1'b0;
      primed_d   <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_ptr == DEPTH) begin
            state    <= RUN;
            in_ready <= 1'b1;
          end else begin
            ram_waddr <= clr_ptr[ADDRESS_WIDTH-1:0];
            ram_wdata <= '0;
            clr_ptr   <= clr_ptr + ONE;
          end
        end
        RUN: begin
          in_ready <= 1'b1;
          // Without an accept the write port holds, so the RAM rewrites identical data.
          if (accept) begin
            ram_waddr <= wp;
            ram_wdata <= in_data;
            ram_raddr <= wp - offset;
            wp        <= wp + 1'b1;
            offset_q  <= offset;
            acc_d     <= 1'b1;
            if (offset_changed) begin
              fill     <= ONE;
              primed_d <= 1'b0;
            end else begin
              primed_d <= (fill >= eff_offset);
              if (fill != DEPTH) fill <= fill + ONE;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_delay_writer.sv
// Bench for ram_delay_writer with a behavioural sample RAM and a history-based reference model.
module tb_ram_delay_writer;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] offset = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_primed;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] snap [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] hist[$];
  int            fill_m = 0;
  int            last_off = 0;

  always #5 clk = ~clk;

  ram_delay_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .offset(offset), .out_valid(out_valid), .out_data(out_data), .out_primed(out_primed),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // Dual-port RAM: writes every cycle, registered read returns pre-write content.
  always @(posedge clk) begin
    ram_rdata       <= mem[ram_raddr];
    mem[ram_waddr]  <= ram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one expected entry per out_valid pulse.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      logic [DW:0] e;
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e[DW-1:0]});
        check("out_primed", {31'd0, out_primed}, {31'd0, e[DW]});
      end
    end
  end

  // Reference: output is the sample accepted eff_offset accepts ago (zero before that history exists).
  task automatic model_accept(input logic [DW-1:0] d, input int off);
    int eff, n;
    logic [DW-1:0] ed;
    logic ep;
    eff = (off == 0) ? DEPTH : off;
    n = hist.size();
    ed = (n >= eff) ? hist[n - eff] : '0;
    if (off != last_off) begin
      ep = 1'b0;
      fill_m = 1;
    end else begin
      ep = (fill_m >= eff);
      if (fill_m < DEPTH) fill_m++;
    end
    last_off = off;
    hist.push_back(d);
    exp_q.push_back({ep, ed});
  endtask

  task automatic send(input logic [DW-1:0] d, input int off);
    in_valid = 1'b1;
    in_data  = d;
    offset   = AW'(off);
    @(posedge clk);
    if (in_ready === 1'b1) model_accept(d, off);
    else check("send_not_ready", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    int lowc;
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    hist.delete();
    fill_m = 0;
    last_off = 0;
    @(negedge clk);
    rst = 1'b0;
    lowc = 0;
    while (in_ready !== 1'b1 && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    check("ready_low_cycles", lowc, 17);
    for (int i = 0; i < DEPTH; i++) check("ram_cleared", {24'd0, mem[i]}, 32'd0);
  endtask

  initial begin
    int diff, p0, off, gap;
    do_reset();

    // Short delay fills up, then a mid-stream offset change.
    for (int i = 0; i < 4; i++) send(DW'(8'h10 + i), 3);
    for (int i = 0; i < 10; i++) send(DW'(8'h20 + i), 5);
    idle(4);

    // Full-depth delay via offset 0.
    do_reset();
    for (int i = 1; i <= 17; i++) send(DW'(i), 0);
    idle(4);

    // Gapped input: RAM must not change while idle.
    for (int i = 0; i < 6; i++) begin
      send(DW'(8'h40 + i), 2);
      @(negedge clk);
      for (int k = 0; k < DEPTH; k++) snap[k] = mem[k];
      @(negedge clk);
      diff = 0;
      for (int k = 0; k < DEPTH; k++) if (mem[k] !== snap[k]) diff++;
      check("ram_hold_idle", diff, 0);
    end
    idle(4);
    check("queue_drained_gaps", exp_q.size(), 0);

    // Randomized stream with occasional offset changes and gaps.
    off = 7;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) off = $urandom_range(0, DEPTH - 1);
      send(DW'($urandom_range(0, 255)), off);
      gap = $urandom_range(0, 2);
      idle(gap);
    end
    idle(4);
    check("queue_drained_random", exp_q.size(), 0);

    // Reset one cycle after an accept must swallow the pending pulse.
    send(8'h77, 3);
    p0 = pulse_cnt;
    do_reset();
    check("no_pulse_after_reset", pulse_cnt, p0);
    send(8'h55, 1);
    send(8'h66, 1);
    idle(4);
    check("queue_drained_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
